// File: rtl/mem_arb_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    RET_NONE = 2'd0,
    RET_I    = 2'd1,
    RET_D    = 2'd2
  } ret_owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive fetch denials; starved is high at the limit.
// Updates next cycle. Has no handshake and so never stalls.
module arb_starve_counter
  import mem_arb_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                inc,
  input  logic                clr,
  input  logic [STARVE_W-1:0] sat,
  output logic                starved
);

  logic [STARVE_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != sat)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starved = (cnt == sat);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port RAM (1-cycle read) between fetch and data. Data has priority; fetch wins after STARVE_MAX denials.
// Read data returns 1 cycle after grant, and the loser is stalled. ARB_PERF_CNT_EN adds stall-cycle counters.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int ADDR_SIZE  = 10,
  parameter int STARVE_MAX = 3
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 CLEAR,
  input  logic                 if_req,
  input  logic [ADDR_SIZE-1:0] if_addr,
  output logic [DATA_SIZE-1:0] if_rdata,
  output logic                 if_valid,
  input  logic                 d_re,
  input  logic                 d_we,
  input  logic [ADDR_SIZE-1:0] d_addr,
  input  logic [DATA_SIZE-1:0] d_wdata,
  output logic [DATA_SIZE-1:0] d_rdata,
  output logic                 d_valid,
  output logic                 stall_if,
  output logic                 stall_mem,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]          perf_if_stall,
  output logic [31:0]          perf_mem_stall,
`endif
  input  logic [DATA_SIZE-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] STARVE_SAT = STARVE_W'(STARVE_MAX);

  logic       d_req;
  logic       d_rd;
  logic       starved;
  logic       grant_i;
  logic       grant_d;
  ret_owner_t ret_owner;
  ret_owner_t ret_next;
  logic       wr_done;
  logic [DATA_SIZE-1:0] if_rdata_q;
  logic [DATA_SIZE-1:0] d_rdata_q;

  // If load and store are both raised, the request is a store.
  assign d_req = d_re | d_we;
  assign d_rd  = d_re & ~d_we;

  assign grant_i = if_req & (~d_req | starved);
  assign grant_d = d_req & ~grant_i;

  assign stall_if  = if_req & ~grant_i;
  assign stall_mem = d_req & ~grant_d;

  always_comb begin
    mem_addr = '0;
    if (grant_i) begin
      mem_addr = if_addr;
    end else if (grant_d) begin
      mem_addr = d_addr;
    end
  end

  assign mem_re    = grant_i | (grant_d & d_rd);
  assign mem_we    = grant_d & d_we;
  assign mem_wdata = d_wdata;

  arb_starve_counter u_starve (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .inc     (stall_if),
    .clr     (grant_i | CLEAR),
    .sat     (STARVE_SAT),
    .starved (starved)
  );

  // A flush only discards fetch returns; an in-flight load still completes.
  always_comb begin
    ret_next = RET_NONE;
    if (grant_i) begin
      ret_next = CLEAR ? RET_NONE : RET_I;
    end else if (grant_d && d_rd) begin
      ret_next = RET_D;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ret_owner <= RET_NONE;
      wr_done   <= 1'b0;
    end else begin
      ret_owner <= ret_next;
      wr_done   <= grant_d & d_we;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (ret_owner == RET_I) begin
        if_rdata_q <= mem_rdata;
      end
      if (ret_owner == RET_D) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  assign if_valid = (ret_owner == RET_I);
  assign if_rdata = if_valid ? mem_rdata : if_rdata_q;
  assign d_valid  = (ret_owner == RET_D) | wr_done;
  assign d_rdata  = (ret_owner == RET_D) ? mem_rdata : d_rdata_q;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      perf_if_stall  <= '0;
      perf_mem_stall <= '0;
    end else begin
      if (stall_if) begin
        perf_if_stall <= perf_if_stall + 32'd1;
      end
      if (stall_mem) begin
        perf_mem_stall <= perf_mem_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: registered RAM model, per-cycle arbitration model, return-data scoreboard.
module tb_unified_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int SM = 3;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          CLEAR;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_re;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          stall_if;
  logic          stall_mem;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   perf_if_stall;
  logic [31:0]   perf_mem_stall;
`endif

  unified_mem_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .STARVE_MAX(SM)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .CLEAR     (CLEAR),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_re      (d_re),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
`ifdef ARB_PERF_CNT_EN
    .perf_if_stall  (perf_if_stall),
    .perf_mem_stall (perf_mem_stall),
`endif
    .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Bench-side model state
  int            m_cnt;
  bit            m_ret_i, m_ret_d, m_wr;
  logic [DW-1:0] m_if_last, m_d_last;
  logic [DW-1:0] q_if[$];
  logic [DW-1:0] q_d[$];

  task automatic model_reset();
    m_cnt = 0; m_ret_i = 0; m_ret_d = 0; m_wr = 0;
    m_if_last = '0; m_d_last = '0;
    q_if.delete(); q_d.delete();
  endtask

  task automatic step(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dw,
                      input logic [AW-1:0] da, input logic [DW-1:0] wd, input bit clr);
    bit dreq, gi, gd;
    logic [AW-1:0] ea;
    @(negedge CLK);
    if_req = ir; if_addr = ia; d_re = dr; d_we = dw; d_addr = da; d_wdata = wd; CLEAR = clr;
    #1;
    check_val("if_valid", if_valid, m_ret_i);
    if (m_ret_i) m_if_last = q_if.pop_front();
    check_val("if_rdata", if_rdata, m_if_last);
    check_val("d_valid", d_valid, m_ret_d | m_wr);
    if (m_ret_d) m_d_last = q_d.pop_front();
    check_val("d_rdata", d_rdata, m_d_last);
    dreq = dr | dw;
    gi = ir & (~dreq | (m_cnt == SM));
    gd = dreq & ~gi;
    ea = gi ? ia : (gd ? da : '0);
    check_val("stall_if", stall_if, ir & ~gi);
    check_val("stall_mem", stall_mem, dreq & ~gd);
    check_val("mem_re", mem_re, gi | (gd & dr & ~dw));
    check_val("mem_we", mem_we, gd & dw);
    check_val("mem_addr", mem_addr, ea);
    check_val("mem_wdata", mem_wdata, wd);
    m_ret_i = gi & ~clr;
    m_ret_d = gd & dr & ~dw;
    m_wr    = gd & dw;
    if (m_ret_i) q_if.push_back(ram[ia]);
    if (m_ret_d) q_d.push_back(ram[da]);
    if (gi || clr) m_cnt = 0;
    else if (ir && m_cnt < SM) m_cnt = m_cnt + 1;
  endtask

  task automatic idle();
    step(0, '0, 0, 0, '0, '0, 0);
  endtask

  bit exp_si [5] = '{1, 1, 1, 0, 1};
  bit exp_sm [5] = '{0, 0, 0, 1, 0};
`ifdef ARB_PERF_CNT_EN
  logic [31:0] base_if, base_mem;
`endif

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
    ram[5] = 32'h0050_0093;
    RESET_N = 0; CLEAR = 0; if_req = 0; if_addr = '0; d_re = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    model_reset();
    #12;
    check_val("rst_if_valid", if_valid, 0);
    check_val("rst_d_valid", d_valid, 0);
    check_val("rst_if_rdata", if_rdata, 0);
    check_val("rst_d_rdata", d_rdata, 0);
    check_val("rst_stall_if", stall_if, 0);
    check_val("rst_mem_re", mem_re, 0);
    @(negedge CLK);
    RESET_N = 1;

    // Fetch only
    step(1, 10'd5, 0, 0, '0, '0, 0);
    idle();
    check_val("t1_if_valid", if_valid, 1);
    check_val("t1_if_rdata", if_rdata, 32'h0050_0093);

    // Simultaneous fetch and load: load first, then fetch
    step(1, 10'd8, 1, 0, 10'd20, '0, 0);
    check_val("t2_stall_if", stall_if, 1);
    check_val("t2_mem_addr", mem_addr, 20);
    step(1, 10'd8, 0, 0, '0, '0, 0);
    check_val("t2_d_valid", d_valid, 1);
    check_val("t2_grant_i", stall_if, 0);
    idle();

    // Starvation under continuous stores
`ifdef ARB_PERF_CNT_EN
    base_if = perf_if_stall; base_mem = perf_mem_stall;
`endif
    for (int k = 0; k < 5; k++) begin
      step(1, 10'd30, 0, 1, 10'(40 + k), 32'hC0DE_0000 + k, 0);
      check_val($sformatf("t3_stall_if_%0d", k), stall_if, exp_si[k]);
      check_val($sformatf("t3_stall_mem_%0d", k), stall_mem, exp_sm[k]);
`ifdef ARB_PERF_CNT_EN
      if (k == 4) begin
        check_val("perf_if", perf_if_stall - base_if, 3);
        check_val("perf_mem", perf_mem_stall - base_mem, 1);
      end
`endif
    end
    step(0, '0, 1, 0, 10'd42, '0, 0);
    step(0, '0, 1, 0, 10'd43, '0, 0);
    check_val("t3_rd42", d_rdata, 32'hC0DE_0002);

    // CLEAR drops fetch return, keeps data return, resets starvation count
    step(1, 10'd12, 0, 0, '0, '0, 1);
    idle();
    check_val("t4_if_flushed", if_valid, 0);
    step(0, '0, 1, 0, 10'd50, '0, 1);
    idle();
    check_val("t4_d_kept", d_valid, 1);
    step(1, 10'd3, 0, 1, 10'd60, 32'h1, 0);
    step(1, 10'd3, 0, 1, 10'd61, 32'h2, 0);
    step(1, 10'd3, 0, 1, 10'd62, 32'h3, 1);
    step(1, 10'd3, 0, 1, 10'd63, 32'h4, 0);
    check_val("t4_cnt_cleared", stall_if, 1);
    idle();

    // Reset while a load return is pending
    step(0, '0, 1, 0, 10'd70, '0, 0);
    @(posedge CLK);
    #2;
    RESET_N = 0; d_re = 0;
    #1;
    check_val("t5_d_valid", d_valid, 0);
    check_val("t5_d_rdata", d_rdata, 0);
    check_val("t5_if_rdata", if_rdata, 0);
    check_val("t5_mem_re", mem_re, 0);
    @(negedge CLK);
    RESET_N = 1;
    model_reset();
    idle();
    check_val("t5_no_valid", d_valid, 0);

    // Random back-to-back traffic
    for (int n = 0; n < 60; n++) begin
      step(bit'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0),
           10'($urandom_range(0, 15)), $urandom, bit'($urandom_range(0, 7) == 0));
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
